// File: rtl/myo_spi_frame_master_if.sv
// Pin and controller-side bundle of one myo SPI frame master.
// MYO_SPI_RX_CHECK_EN adds the frame_error strobe.
interface myo_spi_frame_master_if;
    logic        start_frame;
    logic [15:0] pwm_ref;
    logic        busy;
    logic        ss_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [31:0] position;
    logic [15:0] velocity;
    logic [15:0] displacement;
    logic [15:0] current;
    logic        update_controller;
    logic [15:0] frame_count;
`ifdef MYO_SPI_RX_CHECK_EN
    logic        frame_error;

    modport master (
        input  start_frame, pwm_ref, miso,
        output busy, ss_n, sclk, mosi, position, velocity, displacement, current,
        output update_controller, frame_count, frame_error
    );
    modport slave (
        output start_frame, pwm_ref, miso,
        input  busy, ss_n, sclk, mosi, position, velocity, displacement, current,
        input  update_controller, frame_count, frame_error
    );
`else
    modport master (
        input  start_frame, pwm_ref, miso,
        output busy, ss_n, sclk, mosi, position, velocity, displacement, current,
        output update_controller, frame_count
    );
    modport slave (
        output start_frame, pwm_ref, miso,
        input  busy, ss_n, sclk, mosi, position, velocity, displacement, current,
        input  update_controller, frame_count
    );
`endif
endinterface

// File: rtl/myo_spi_frame_master.sv
// SPI mode-0 frame master for one myo motor board: sends the PWM reference, latches sensor words.
// Define MYO_SPI_RX_CHECK_EN to reject frames whose RX word 0 is not the echoed 0x8000 marker.
module myo_spi_frame_master #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned N_WORDS     = 7,
    parameter int unsigned UPDATE_HOLD = 2
) (
    input logic                    clock,
    input logic                    reset,
    myo_spi_frame_master_if.master bus
);
    localparam logic [15:0] DivLast  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HoldLast = 16'(UPDATE_HOLD);
    localparam logic [7:0]  LastBit  = 8'(16 * N_WORDS - 1);
    localparam logic [15:0] Marker   = 16'h8000;

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StLatch, StUpdate, StGap} state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [7:0]  bit_cnt_q;
    logic [15:0] pwm_q;
    logic [14:0] rx_shift_q;
    logic [15:0] rx_pos_hi_q, rx_pos_lo_q, rx_vel_q, rx_disp_q, rx_cur_q;
    logic        busy_q, ss_n_q, sclk_q, mosi_q, update_q;
    logic [31:0] position_q;
    logic [15:0] velocity_q, displacement_q, current_q, frame_cnt_q;
    logic [15:0] rx_word;
    logic [7:0]  next_bit;
    logic        rx_ok;

    assign rx_word  = {rx_shift_q, bus.miso};
    assign next_bit = bit_cnt_q + 8'd1;

`ifdef MYO_SPI_RX_CHECK_EN
    logic [15:0] rx_w0_q;
    logic        frame_error_q;
    assign rx_ok           = (rx_w0_q == Marker);
    assign bus.frame_error = frame_error_q;
`else
    assign rx_ok = 1'b1;
`endif

    // TX layout: marker, PWM reference, then zero padding.
    function automatic logic tx_bit(input logic [7:0] idx, input logic [15:0] pwm);
        logic [15:0] word;
        if (idx[7:4] == 4'd0) begin
            word = Marker;
        end else if (idx[7:4] == 4'd1) begin
            word = pwm;
        end else begin
            word = 16'h0000;
        end
        return word[4'd15 - idx[3:0]];
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            bit_cnt_q      <= '0;
            pwm_q          <= '0;
            rx_shift_q     <= '0;
            rx_pos_hi_q    <= '0;
            rx_pos_lo_q    <= '0;
            rx_vel_q       <= '0;
            rx_disp_q      <= '0;
            rx_cur_q       <= '0;
            busy_q         <= 1'b0;
            ss_n_q         <= 1'b1;
            sclk_q         <= 1'b0;
            mosi_q         <= 1'b0;
            update_q       <= 1'b0;
            position_q     <= '0;
            velocity_q     <= '0;
            displacement_q <= '0;
            current_q      <= '0;
            frame_cnt_q    <= '0;
`ifdef MYO_SPI_RX_CHECK_EN
            rx_w0_q        <= '0;
            frame_error_q  <= 1'b0;
`endif
        end else begin
`ifdef MYO_SPI_RX_CHECK_EN
            frame_error_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (bus.start_frame) begin
                        pwm_q     <= bus.pwm_ref;
                        busy_q    <= 1'b1;
                        ss_n_q    <= 1'b0;
                        mosi_q    <= tx_bit(8'd0, bus.pwm_ref);
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_q == DivLast) begin
                        cnt_q      <= '0;
                        sclk_q     <= 1'b1;
                        rx_shift_q <= rx_word[14:0];
                        state_q    <= StShift;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StShift: begin
                    if (cnt_q != DivLast) begin
                        cnt_q <= cnt_q + 16'd1;
                    end else begin
                        cnt_q <= '0;
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            mosi_q <= (bit_cnt_q == LastBit) ? 1'b0 : tx_bit(next_bit, pwm_q);
                        end else if (bit_cnt_q == LastBit) begin
                            state_q <= StHold;
                        end else begin
                            // Sample MISO on the edge that raises SCLK.
                            sclk_q     <= 1'b1;
                            bit_cnt_q  <= next_bit;
                            rx_shift_q <= rx_word[14:0];
                            if (next_bit[3:0] == 4'hF) begin
                                case (next_bit[7:4])
`ifdef MYO_SPI_RX_CHECK_EN
                                    4'd0:    rx_w0_q     <= rx_word;
`endif
                                    4'd2:    rx_pos_hi_q <= rx_word;
                                    4'd3:    rx_pos_lo_q <= rx_word;
                                    4'd4:    rx_vel_q    <= rx_word;
                                    4'd5:    rx_disp_q   <= rx_word;
                                    4'd6:    rx_cur_q    <= rx_word;
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                StHold: begin
                    if (cnt_q == DivLast) begin
                        cnt_q   <= '0;
                        ss_n_q  <= 1'b1;
                        state_q <= StLatch;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StLatch: begin
                    // All data outputs move together so position never mixes frames.
                    if (rx_ok) begin
                        position_q     <= {rx_pos_hi_q, rx_pos_lo_q};
                        velocity_q     <= rx_vel_q;
                        displacement_q <= rx_disp_q;
                        current_q      <= rx_cur_q;
                        frame_cnt_q    <= frame_cnt_q + 16'd1;
                        state_q        <= StUpdate;
                    end else begin
`ifdef MYO_SPI_RX_CHECK_EN
                        frame_error_q <= 1'b1;
`endif
                        state_q <= StGap;
                    end
                end
                StUpdate: begin
                    if (cnt_q == HoldLast) begin
                        cnt_q    <= '0;
                        update_q <= 1'b0;
                        state_q  <= StGap;
                    end else begin
                        cnt_q    <= cnt_q + 16'd1;
                        update_q <= 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q == DivLast) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy              = busy_q;
    assign bus.ss_n              = ss_n_q;
    assign bus.sclk              = sclk_q;
    assign bus.mosi              = mosi_q;
    assign bus.position          = position_q;
    assign bus.velocity          = velocity_q;
    assign bus.displacement      = displacement_q;
    assign bus.current           = current_q;
    assign bus.update_controller = update_q;
    assign bus.frame_count       = frame_cnt_q;
endmodule

// File: tb/tb_myo_spi_frame_master.sv
// Scoreboard bench for myo_spi_frame_master: a slave model answers on MISO, a monitor checks frames.
`timescale 1ns/1ps
module tb_myo_spi_frame_master;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    myo_spi_frame_master_if bus ();

    myo_spi_frame_master #(
        .CLK_DIV    (4),
        .N_WORDS    (7),
        .UPDATE_HOLD(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [111:0] tx;
        logic [31:0]  pos;
        logic [15:0]  vel;
        logic [15:0]  disp;
        logic [15:0]  cur;
        logic [15:0]  fc;
        bit           latch;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          frames_seen = 0;
    int          pulses = 0;
    int          exp_frames = 0;
    int          exp_pulses = 0;
    logic [15:0] slave_words[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Slave: first bit valid once ss_n falls, next bit after every SCLK falling edge.
    int   s_idx = 0;
    logic s_prev_sclk = 1'b0;
    always @(negedge clock) begin
        logic [15:0] w;
        if (bus.ss_n) begin
            s_idx    = 0;
            bus.miso = 1'b0;
        end else begin
            if (s_prev_sclk && !bus.sclk) s_idx++;
            if (s_idx < 112) begin
                w        = slave_words[s_idx / 16];
                bus.miso = w[15 - (s_idx % 16)];
            end else begin
                bus.miso = 1'b0;
            end
        end
        s_prev_sclk = bus.sclk;
    end

    // Monitor: pops the expected frame when ss_n rises, checks outputs when the update pulse ends.
    int           low_cnt = 0;
    int           since_ss = 0;
    int           uc_len = 0;
    bit           in_frame = 0;
    bit           have_cur = 0;
    logic         prev_sclk = 1'b0;
    logic [111:0] mosi_cap = '0;
    exp_t         cur;
    always @(negedge clock) begin
        if (reset) begin
            in_frame  = 0;
            have_cur  = 0;
            uc_len    = 0;
            since_ss  = 0;
            prev_sclk = 1'b0;
        end else begin
            since_ss++;
            if (!bus.ss_n) begin
                if (!in_frame) begin
                    in_frame = 1;
                    low_cnt  = 0;
                    mosi_cap = '0;
                    frames_seen++;
                end
                low_cnt++;
                if (bus.sclk && !prev_sclk) mosi_cap = {mosi_cap[110:0], bus.mosi};
            end else if (in_frame) begin
                in_frame = 0;
                since_ss = 0;
                chk("frame_expected", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("ss_low_cycles", 128'(low_cnt), 128'(904));
                    chk("mosi_words", 128'(mosi_cap), 128'(cur.tx));
                    have_cur = cur.latch;
                end
            end
            prev_sclk = bus.sclk;
            if (bus.update_controller) begin
                uc_len++;
                if (uc_len == 1) chk("update_delay", 128'(since_ss), 128'(2));
            end else if (uc_len > 0) begin
                pulses++;
                chk("update_expected", 128'(have_cur), 128'(1));
                chk("update_len", 128'(uc_len), 128'(2));
                if (have_cur) begin
                    chk("position", 128'(bus.position), 128'(cur.pos));
                    chk("velocity", 128'(bus.velocity), 128'(cur.vel));
                    chk("displacement", 128'(bus.displacement), 128'(cur.disp));
                    chk("current", 128'(bus.current), 128'(cur.cur));
                    chk("frame_count", 128'(bus.frame_count), 128'(cur.fc));
                end
                have_cur = 0;
                uc_len   = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_words(input logic [15:0] w0, input logic [15:0] w2, input logic [15:0] w3,
                             input logic [15:0] w4, input logic [15:0] w5, input logic [15:0] w6);
        slave_words[0] = w0;
        slave_words[1] = 16'h0000;
        slave_words[2] = w2;
        slave_words[3] = w3;
        slave_words[4] = w4;
        slave_words[5] = w5;
        slave_words[6] = w6;
    endtask

    task automatic expect_frame(input logic [15:0] pwm, input logic [31:0] pos,
                                input logic [15:0] vel, input logic [15:0] disp,
                                input logic [15:0] cr, input logic [15:0] fc, input bit latch);
        exp_t e;
        e.tx    = {16'h8000, pwm, 80'h0};
        e.pos   = pos;
        e.vel   = vel;
        e.disp  = disp;
        e.cur   = cr;
        e.fc    = fc;
        e.latch = latch;
        exp_q.push_back(e);
        exp_frames++;
        if (latch) exp_pulses++;
    endtask

    task automatic start(input logic [15:0] pwm);
        @(negedge clock);
        bus.start_frame = 1'b1;
        bus.pwm_ref     = pwm;
        @(negedge clock);
        bus.start_frame = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk(name, 128'(bus.busy), 128'(0));
    endtask

    task automatic wait_sclk_rises(input int n);
        int   seen = 0;
        int   t = 0;
        logic p = bus.sclk;
        while (seen < n && t < 2000) begin
            @(negedge clock);
            t++;
            if (bus.sclk && !p) seen++;
            p = bus.sclk;
        end
        chk("sclk_rises", 128'(seen), 128'(n));
    endtask

    initial begin
        reset           = 1'b1;
        bus.start_frame = 1'b0;
        bus.pwm_ref     = 16'h0000;
        set_words(16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick(3);
        reset = 1'b0;
        tick(50);
        chk("idle_ss_n", 128'(bus.ss_n), 128'(1));
        chk("idle_sclk", 128'(bus.sclk), 128'(0));
        chk("idle_busy", 128'(bus.busy), 128'(0));
        chk("idle_mosi", 128'(bus.mosi), 128'(0));
        chk("idle_position", 128'(bus.position), 128'(0));
        chk("idle_velocity", 128'(bus.velocity), 128'(0));
        chk("idle_displacement", 128'(bus.displacement), 128'(0));
        chk("idle_current", 128'(bus.current), 128'(0));
        chk("idle_frame_count", 128'(bus.frame_count), 128'(0));
`ifdef MYO_SPI_RX_CHECK_EN
        chk("idle_frame_error", 128'(bus.frame_error), 128'(0));
`endif

        // Frame A; a start 100 cycles in must be dropped and the pwm_ref change ignored.
        set_words(16'h8000, 16'h0001, 16'h86A0, 16'hFFF6, 16'h0050, 16'h0123);
        expect_frame(16'h1234, 32'd100000, 16'hFFF6, 16'h0050, 16'h0123, 16'd1, 1);
        start(16'h1234);
        tick(98);
        chk("busy_mid_frame", 128'(bus.busy), 128'(1));
        start(16'h5555);
        wait_idle("busy_a");

        // Frame B, accepted once busy is low.
        set_words(16'h8000, 16'hFFFF, 16'hFFFE, 16'h0007, 16'h1000, 16'h0ABC);
        expect_frame(16'h8001, 32'hFFFF_FFFE, 16'h0007, 16'h1000, 16'h0ABC, 16'd2, 1);
        start(16'h8001);
        wait_idle("busy_b");

        // Frame C aborted by reset partway through.
        set_words(16'h8000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        exp_frames++;
        start(16'h0F0F);
        wait_sclk_rises(61);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_ss_n", 128'(bus.ss_n), 128'(1));
        chk("abort_sclk", 128'(bus.sclk), 128'(0));
        chk("abort_busy", 128'(bus.busy), 128'(0));
        chk("abort_position", 128'(bus.position), 128'(0));
        chk("abort_velocity", 128'(bus.velocity), 128'(0));
        chk("abort_displacement", 128'(bus.displacement), 128'(0));
        chk("abort_current", 128'(bus.current), 128'(0));
        chk("abort_frame_count", 128'(bus.frame_count), 128'(0));
        tick(2);
        reset = 1'b0;
        tick(20);
        chk("abort_stays_idle", 128'(bus.ss_n), 128'(1));

        // Frame D after the abort.
        set_words(16'h8000, 16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 16'h0000);
        expect_frame(16'h7FFF, 32'h0000_0001, 16'h8000, 16'hFFFF, 16'h0000, 16'd1, 1);
        start(16'h7FFF);
        wait_idle("busy_d");

        // Frame E from a forced 0xFFFF count must wrap to 0.
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clock);
        release dut.frame_cnt_q;
        tick(2);
        chk("preload_count", 128'(bus.frame_count), 128'(16'hFFFF));
        set_words(16'h8000, 16'h8000, 16'h0000, 16'h0001, 16'h0002, 16'h0003);
        expect_frame(16'h0001, 32'h8000_0000, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 1);
        start(16'h0001);
        wait_idle("busy_e");

`ifdef MYO_SPI_RX_CHECK_EN
        begin
            int fe_cnt = 0;
            int n = 0;
            set_words(16'h7FFF, 16'h1234, 16'h5678, 16'h0BAD, 16'h0C0D, 16'h0E0F);
            expect_frame(16'h00AA, 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0);
            start(16'h00AA);
            while (bus.busy && n < 3000) begin
                @(negedge clock);
                n++;
                if (bus.frame_error) fe_cnt++;
            end
            chk("busy_err", 128'(bus.busy), 128'(0));
            chk("frame_error_pulses", 128'(fe_cnt), 128'(1));
            chk("err_position", 128'(bus.position), 128'(32'h8000_0000));
            chk("err_velocity", 128'(bus.velocity), 128'(16'h0001));
            chk("err_displacement", 128'(bus.displacement), 128'(16'h0002));
            chk("err_current", 128'(bus.current), 128'(16'h0003));
            chk("err_frame_count", 128'(bus.frame_count), 128'(16'h0000));
        end
        set_words(16'h8000, 16'h0000, 16'h0064, 16'hFF00, 16'h0042, 16'h0099);
        expect_frame(16'h0055, 32'h0000_0064, 16'hFF00, 16'h0042, 16'h0099, 16'h0001, 1);
        start(16'h0055);
        wait_idle("busy_g");
`endif

        tick(20);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        chk("frames_on_bus", 128'(frames_seen), 128'(exp_frames));
        chk("update_pulses", 128'(pulses), 128'(exp_pulses));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
